// File: rtl/uart_tx_serializer_if.sv
// rtl/uart_tx_serializer_if.sv - word handshake between a host producer and the UART transmitter
//
// Signals:
//   tx_valid  producer -> tx  word present on tx_data
//   tx_data   producer -> tx  DATA_W-bit word, sampled only on handshake
//   tx_ready  tx -> producer  transmitter can accept a word this cycle
// Modports: master = producer side, slave = transmitter side.
interface uart_tx_serializer_if #(
  parameter int DATA_W = 8
);
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ready;

  modport master (
    output tx_valid,
    output tx_data,
    input  tx_ready
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - parallel-in serial-out asynchronous (UART) transmitter
//
// Frames each accepted word as start bit, DATA_W data bits, optional even
// parity bit and STOP_BITS stop bits, each bit held for CLKS_PER_BIT clocks.
//
// Ports:
//   clk    system clock, rising edge
//   rst    synchronous reset, active-low
//   s_tx   uart_tx_serializer_if.slave (tx_valid, tx_data, tx_ready)
//   txd    registered serial line, idle high
//   busy   frame in progress
//
// Optional feature macro: UART_TX_PARITY_EN (adds an even-parity bit after the data).
`ifndef SHIFT_DIR_RIGHT
`define SHIFT_DIR_RIGHT 0
`endif
`ifndef SHIFT_DIR_LEFT
`define SHIFT_DIR_LEFT 1
`endif

module uart_tx_serializer #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int SHIFT_DIR    = `SHIFT_DIR_RIGHT
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_tx_serializer_if.slave  s_tx,
  output logic                 txd,
  output logic                 busy
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t              r_state;
  logic [BAUD_W-1:0]   r_baud;
  logic [BIT_W-1:0]    r_bit;
  logic [DATA_W-1:0]   r_shift;
  logic                r_txd;
  logic                r_busy;
  logic                r_ready;
`ifdef UART_TX_PARITY_EN
  logic                r_parity;
`endif

  logic                w_bit_end;
  logic [DATA_W-1:0]   w_shifted;
  logic                w_out_cur;
  logic                w_out_next;

  assign w_bit_end = (r_baud == BAUD_LAST);

  // The outgoing bit always sits at the end of the register that leaves
  // first, so the register moves one place toward that end per data bit.
  assign w_shifted  = (SHIFT_DIR == `SHIFT_DIR_LEFT) ? (r_shift << 1) : (r_shift >> 1);
  assign w_out_cur  = (SHIFT_DIR == `SHIFT_DIR_LEFT) ? r_shift[DATA_W-1]   : r_shift[0];
  assign w_out_next = (SHIFT_DIR == `SHIFT_DIR_LEFT) ? w_shifted[DATA_W-1] : w_shifted[0];

  assign s_tx.tx_ready = r_ready;
  assign txd           = r_txd;
  assign busy          = r_busy;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_baud   <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_txd    <= 1'b1;
      r_busy   <= 1'b0;
      r_ready  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_txd   <= 1'b1;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          // r_ready is low on the first cycle after reset, so a waiting
          // producer is only accepted once tx_ready has been visible.
          if (s_tx.tx_valid && r_ready) begin
            r_shift  <= s_tx.tx_data;
`ifdef UART_TX_PARITY_EN
            r_parity <= ^s_tx.tx_data;
`endif
            r_baud   <= '0;
            r_bit    <= '0;
            r_state  <= S_START;
            r_txd    <= 1'b0;
            r_busy   <= 1'b1;
            r_ready  <= 1'b0;
          end
        end

        S_START: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_state <= S_DATA;
            r_txd   <= w_out_cur;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        S_DATA: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (r_bit == DATA_LAST) begin
              r_bit <= '0;
`ifdef UART_TX_PARITY_EN
              r_state <= S_PARITY;
              r_txd   <= r_parity;
`else
              r_state <= S_STOP;
              r_txd   <= 1'b1;
`endif
            end else begin
              r_bit   <= r_bit + 1'b1;
              r_shift <= w_shifted;
              r_txd   <= w_out_next;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_state <= S_STOP;
            r_txd   <= 1'b1;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
`endif

        S_STOP: begin
          r_txd <= 1'b1;
          if (w_bit_end) begin
            r_baud <= '0;
            if (r_bit == STOP_LAST) begin
              r_bit   <= '0;
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_ready <= 1'b1;
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_txd   <= 1'b1;
          r_busy  <= 1'b0;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
Parallel-in, serial-out asynchronous transmitter. It is the transmit end of the serial link whose receive side shifts bits into a shift register.
- Accepts one DATA_W word per valid/ready handshake.
- Frames the word as start bit, data bits, optional parity and stop bit(s).
- Drives each bit on txd for CLKS_PER_BIT clocks.
- Sits between a host-side producer (FIFO or control FSM) and the board TX pin.

Parameters:
DATA_W, 8, data bits per frame (1..16)
CLKS_PER_BIT, 16, clocks per serial bit (>=2)
STOP_BITS, 1, stop bits per frame (1 or 2)
SHIFT_DIR, `SHIFT_DIR_RIGHT, `SHIFT_DIR_RIGHT = LSB first; `SHIFT_DIR_LEFT = MSB first

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous reset, active-low (0 = reset), sampled on rising clk
tx_valid  input  1  producer has a word on tx_data
tx_data  input  DATA_W  word to send; sampled only on handshake
tx_ready  output  1  block can accept a word this cycle
txd  output  1  serial line; idle high
busy  output  1  frame in progress (any state other than IDLE)

Behaviour:
- Reset (rst==0 at a clock edge): state=IDLE, txd=1, tx_ready=0 during reset, busy=0, bit counter=0, baud counter=0, shift register=0.
- Reset mid-frame aborts the frame. txd returns to 1 on the next edge. No partial bits resume.
- tx_ready = (state==IDLE) && rst deasserted. It is a function of registered state only, with no combinational path from tx_valid.
- Handshake: when tx_valid && tx_ready at an edge, tx_data is latched into the shift register and state goes to START. tx_valid without tx_ready is ignored; the producer holds it.
- State machine: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - START: txd=0 for CLKS_PER_BIT clocks.
  - DATA: DATA_W bits, each CLKS_PER_BIT clocks. The shift register moves by one bit at each bit boundary, and the outgoing bit is the LSB (right) or MSB (left).
  - STOP: txd=1 for STOP_BITS*CLKS_PER_BIT clocks.
- Baud counter: counts 0..CLKS_PER_BIT-1, wraps to 0 at the end of each bit, and is cleared on the handshake. Width is clog2(CLKS_PER_BIT).
- Bit counter: counts data bits 0..DATA_W-1 and stop bits 0..STOP_BITS-1. It wraps to 0 on each state change.
- txd is registered. The first start-bit clock is the cycle after the handshake edge, so latency from handshake to txd falling is 1 clock.
- Frame length: (1+DATA_W+P+STOP_BITS)*CLKS_PER_BIT clocks, where P=1 with parity, else 0.
- Back-to-back: after the last stop clock the state is IDLE for one cycle with tx_ready=1. If tx_valid is high then, the next start bit begins the following cycle. Minimum word period = frame length + 1 clock.
- busy=1 from the cycle after the handshake until the return to IDLE.
- tx_data changes while busy have no effect on the frame.

Optional Feature:
UART_TX_PARITY_EN
- Defined: a PARITY state is inserted between DATA and STOP. txd = XOR of the latched data bits (even parity) for CLKS_PER_BIT clocks. Parity is computed at the handshake and held in a register.
- Not defined: the PARITY state, parity register and parity logic are absent, and DATA goes directly to STOP.

Test Plan:
1. Reset values: hold rst=0 for 3 clocks -> txd=1, busy=0, tx_ready=0. Release -> tx_ready=1 on the next cycle.
2. Single frame, DATA_W=8, CLKS_PER_BIT=4, LSB first, send 0xA5:
   - txd=0 for 4 clocks starting 1 clock after the handshake.
   - Then data bits 1,0,1,0,0,1,0,1, 4 clocks each.
   - Then 1 for 4 clocks.
   - busy high for 40 clocks.
3. MSB first, same settings, send 0xA5 -> data bits 1,0,1,0,0,1,0,1 in MSB-first order. Then send 0x01 -> seven 0s then 1.
4. Back-to-back: tx_valid held high with 0x55 then 0xFF -> second start bit falls exactly 41 clocks after the first. tx_ready high for exactly 1 cycle between frames.
5. Mid-frame reset: assert rst=0 during data bit 3 -> txd=1 the next clock, state IDLE. A new word of 0x3C after release is sent intact.
6. With UART_TX_PARITY_EN, send 0x07 -> parity bit = 1 for 4 clocks before the stop bit. Send 0x03 -> parity bit = 0. Frame length 44 clocks.
